// File: rtl/solver_sequencer_pkg.sv
// solver_seq_pkg: shared state encoding and counter widths for the solver sequencer
package solver_seq_pkg;
  localparam int STATE_W = 3;
  localparam int ITER_W = 8;
  typedef enum logic [STATE_W-1:0] {IDLE, LOAD, SETTLE, CONVERT, CHECK, STEP, FINISH} state_t;
endpackage

// File: rtl/solver_sequencer_if.sv
// solver_sequencer_if: solver, DAC and ADC handshake bundle for the solver sequencer
interface solver_sequencer_if
  import solver_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 10
);
  logic start;
  logic abort;
  logic [BUS_WIDTH-1:0] q_desired;
  logic [BUS_WIDTH-1:0] solver_i_ref;
  logic solver_step;
  logic [BUS_WIDTH-1:0] dac_code;
  logic adc_start;
  logic adc_done;
  logic [BUS_WIDTH-1:0] adc_data;
  logic [BUS_WIDTH-1:0] q_measured;
  logic busy;
  logic done;
  logic converged;
  logic timeout;
  logic [ITER_W-1:0] iter_count;
  modport slave (
    input start, abort, q_desired, solver_i_ref, adc_done, adc_data,
    output solver_step, dac_code, adc_start, q_measured, busy, done, converged, timeout, iter_count
  );
  modport master (
    output start, abort, q_desired, solver_i_ref, adc_done, adc_data,
    input solver_step, dac_code, adc_start, q_measured, busy, done, converged, timeout, iter_count
  );
endinterface

// File: rtl/solver_sequencer_tol_compare.sv
// tol_compare: unwrapped absolute difference of two codes checked against a tolerance
module tol_compare #(
  parameter int W = 10
) (
  input logic [W-1:0] a,
  input logic [W-1:0] b,
  input logic [W:0] tol,
  output logic within_tol
);
  logic signed [W:0] diff;
  logic [W:0] mag;
  assign diff = $signed({1'b0, a}) - $signed({1'b0, b});
  assign mag = diff[W] ? -diff : diff;
  assign within_tol = mag < tol;
endmodule

// File: rtl/solver_sequencer.sv
// solver_sequencer: DAC/settle/ADC/check solve loop; SOLVER_SEQ_WATCHDOG_EN adds an ADC watchdog
module solver_sequencer
  import solver_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 10,
  parameter int TOL = 30,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_ITER = 32,
  parameter int ADC_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  solver_sequencer_if.slave bus
);
  localparam int CNT_MAX = SETTLE_CYCLES > ADC_TIMEOUT ? SETTLE_CYCLES : ADC_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 1);
  state_t state_q, state_d;
  logic [BUS_WIDTH-1:0] dac_q, dac_d, meas_q, meas_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic conv_q, conv_d, tmo_q, tmo_d, in_conv_q, adc_ok, within_tol;
  tol_compare #(.W(BUS_WIDTH)) u_tol (
    .a(meas_q),
    .b(bus.q_desired),
    .tol((BUS_WIDTH + 1)'(TOL)),
    .within_tol(within_tol)
  );
  assign iter_inc = &iter_q ? iter_q : iter_q + 1'b1;
  assign adc_ok = state_q == CONVERT && in_conv_q && bus.adc_done;
  always_comb begin
    state_d = state_q;
    dac_d = dac_q;
    meas_d = meas_q;
    iter_d = iter_q;
    cnt_d = cnt_q;
    conv_d = conv_q;
    tmo_d = tmo_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = LOAD;
        iter_d = '0;
        conv_d = 1'b0;
        tmo_d = 1'b0;
      end
      LOAD: begin
        dac_d = bus.solver_i_ref;
        cnt_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (adc_ok) begin
          meas_d = bus.adc_data;
          state_d = CHECK;
        end
`ifdef SOLVER_SEQ_WATCHDOG_EN
        else if (cnt_q == CW'(ADC_TIMEOUT - 1)) begin
          tmo_d = 1'b1;
          state_d = FINISH;
        end
        cnt_d = cnt_q + 1'b1;
`endif
      end
      CHECK: begin
        state_d = within_tol ? FINISH : iter_q == ITER_W'(MAX_ITER - 1) ? FINISH : STEP;
        conv_d = within_tol;
        tmo_d = !within_tol && iter_q == ITER_W'(MAX_ITER - 1);
      end
      STEP: begin
        iter_d = iter_inc;
        state_d = LOAD;
      end
      FINISH: begin
        iter_d = iter_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      dac_d = dac_q;
      meas_d = meas_q;
      iter_d = iter_q;
      conv_d = conv_q;
      tmo_d = tmo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dac_q <= '0;
      meas_q <= '0;
      iter_q <= '0;
      cnt_q <= '0;
      conv_q <= 1'b0;
      tmo_q <= 1'b0;
      in_conv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q <= dac_d;
      meas_q <= meas_d;
      iter_q <= iter_d;
      cnt_q <= cnt_d;
      conv_q <= conv_d;
      tmo_q <= tmo_d;
      in_conv_q <= state_q == CONVERT;
    end
  end
  assign bus.solver_step = state_q == STEP;
  assign bus.adc_start = state_q == CONVERT && !in_conv_q;
  assign bus.done = state_q == FINISH;
  assign bus.busy = state_q != IDLE;
  assign bus.dac_code = dac_q;
  assign bus.q_measured = meas_q;
  assign bus.converged = conv_q;
  assign bus.timeout = tmo_q;
  assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_solver_sequencer.sv
// tb_solver_sequencer: randomized self-checking bench against a solve-outcome reference model
module tb_solver_sequencer;
  localparam int BW = 10;
  localparam int TOL = 30;
  localparam int SC = 16;
  localparam int MI = 4;
  localparam int AT = 64;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] adc_vals[$];
  int delays[$];
  int lat, steps, starts;
  bit overlap, got_done, meas_moved;
  logic [BW-1:0] last_ref;
  always #5 clk = ~clk;
  solver_sequencer_if #(.BUS_WIDTH(BW)) bus ();
  solver_sequencer #(
    .BUS_WIDTH(BW),
    .TOL(TOL),
    .SETTLE_CYCLES(SC),
    .MAX_ITER(MI),
    .ADC_TIMEOUT(AT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [BW-1:0] qd, input logic [BW-1:0] vals[$], output int n, output bit conv);
    int e;
    n = MI;
    conv = 1'b0;
    for (int k = 0; k < MI; k++) begin
      e = int'(vals[k]) - int'(qd);
      if (e < 0) e = -e;
      if (e < TOL) begin
        n = k + 1;
        conv = 1'b1;
        break;
      end
    end
  endfunction
  task automatic run_solve(input logic [BW-1:0] qd, input logic [BW-1:0] ref0, input int max_delay, input bit noise);
    int wait_cnt = 0;
    int d;
    bit seen = 1'b0;
    logic [BW-1:0] m0 = bus.q_measured;
    lat = 0;
    steps = 0;
    starts = 0;
    overlap = 1'b0;
    got_done = 1'b0;
    meas_moved = 1'b0;
    delays.delete();
    bus.q_desired = qd;
    bus.solver_i_ref = ref0;
    last_ref = ref0;
    bus.abort = 1'b0;
    bus.adc_done = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 3000 && !got_done; c++) begin
      tick();
      bus.start = 1'b0;
      bus.adc_done = 1'b0;
      if (int'(bus.solver_step) + int'(bus.adc_start) + int'(bus.done) > 1) overlap = 1'b1;
      steps += int'(bus.solver_step);
      starts += int'(bus.adc_start);
      if (bus.done) begin
        got_done = 1'b1;
        lat = c;
      end
      if (bus.solver_step) begin
        bus.solver_i_ref = BW'($urandom);
        last_ref = bus.solver_i_ref;
      end
      if (!seen && bus.q_measured !== m0) meas_moved = 1'b1;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.adc_done = 1'b1;
          bus.adc_data = adc_vals.pop_front();
        end
      end
      if (bus.adc_start) begin
        seen = 1'b1;
        d = int'($urandom_range(max_delay, 0));
        delays.push_back(d);
        wait_cnt = 1 + d;
      end else if (noise && !seen) begin
        bus.start = 1'($urandom);
        bus.adc_done = 1'($urandom);
        bus.adc_data = BW'($urandom);
      end
    end
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.adc_start, bus.solver_step, bus.converged, bus.timeout, bus.dac_code, bus.q_measured, bus.iter_count} !== '0)
      begin errors++; $display("FAIL reset_state: got %h expected 0", {bus.busy, bus.done, bus.adc_start, bus.solver_step, bus.converged, bus.timeout, bus.dac_code, bus.q_measured, bus.iter_count}); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_start_abort_idle();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle: busy got %b expected 0", bus.busy); end
  endtask
  task automatic test_converge_first();
    adc_vals.delete();
    adc_vals.push_back(10'd270);
    run_solve(10'd258, 10'h1A5, 0, 1'b0);
    checks++;
    if (!got_done || lat != SC + 5) begin errors++; $display("FAIL first_latency: done %b lat %0d expected %0d", got_done, lat, SC + 5); end
    checks++;
    if ({bus.converged, bus.timeout, bus.iter_count} !== {1'b1, 1'b0, 8'd1}) begin errors++; $display("FAIL first_flags: conv/tmo/iter got %b/%b/%0d expected 1/0/1", bus.converged, bus.timeout, bus.iter_count); end
    checks++;
    if (steps != 0 || starts != 1 || overlap) begin errors++; $display("FAIL first_pulses: steps %0d starts %0d overlap %b expected 0 1 0", steps, starts, overlap); end
    checks++;
    if ({bus.q_measured, bus.dac_code, bus.busy} !== {10'd270, 10'h1A5, 1'b0}) begin errors++; $display("FAIL first_data: meas %0d dac %h busy %b expected 270 1a5 0", bus.q_measured, bus.dac_code, bus.busy); end
  endtask
  task automatic test_max_iter();
    adc_vals.delete();
    repeat (MI) adc_vals.push_back(10'd500);
    run_solve(10'd258, 10'h055, 0, 1'b0);
    checks++;
    if (steps != MI - 1 || starts != MI || overlap) begin errors++; $display("FAIL maxiter_pulses: steps %0d starts %0d overlap %b expected %0d %0d 0", steps, starts, overlap, MI - 1, MI); end
    checks++;
    if ({bus.converged, bus.timeout, bus.iter_count} !== {1'b0, 1'b1, 8'(MI)}) begin errors++; $display("FAIL maxiter_flags: conv/tmo/iter got %b/%b/%0d expected 0/1/%0d", bus.converged, bus.timeout, bus.iter_count, MI); end
    checks++;
    if (!got_done || lat != MI * (SC + 5)) begin errors++; $display("FAIL maxiter_latency: done %b lat %0d expected %0d", got_done, lat, MI * (SC + 5)); end
  endtask
  task automatic test_tol_boundary();
    logic [BW-1:0] qds[3] = '{10'd100, 10'd5, 10'd1023};
    logic [BW-1:0] tv[3][4] = '{'{10'd130, 10'd70, 10'd129, 10'd500}, '{10'd1023, 10'd0, 10'd1023, 10'd1023}, '{10'd0, 10'd0, 10'd0, 10'd0}};
    int exp_n[3] = '{3, 2, 4};
    bit exp_c[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      adc_vals.delete();
      for (int k = 0; k < 4; k++) adc_vals.push_back(tv[i][k]);
      run_solve(qds[i], BW'($urandom), 1, 1'b0);
      checks++;
      if (!got_done || {bus.converged, bus.timeout, bus.iter_count} !== {exp_c[i], !exp_c[i], 8'(exp_n[i])} || steps != exp_n[i] - 1)
        begin errors++; $display("FAIL tol_boundary_%0d: conv/tmo/iter/steps got %b/%b/%0d/%0d expected %b/%b/%0d/%0d", i, bus.converged, bus.timeout, bus.iter_count, steps, exp_c[i], !exp_c[i], exp_n[i], exp_n[i] - 1); end
    end
  endtask
  task automatic test_random();
    logic [BW-1:0] qd;
    logic [BW-1:0] vals[$];
    int v, n, exp_lat;
    bit conv;
    for (int t = 0; t < 12; t++) begin
      qd = BW'($urandom_range(1023, 0));
      adc_vals.delete();
      for (int k = 0; k < MI; k++) begin
        v = int'(qd) + int'($urandom_range(6 * TOL, 0)) - 3 * TOL;
        v = v < 0 ? 0 : v > 1023 ? 1023 : v;
        adc_vals.push_back(BW'(v));
      end
      vals = adc_vals;
      model(qd, vals, n, conv);
      run_solve(qd, BW'($urandom), 3, 1'b0);
      exp_lat = 1 + n * (SC + 4) + delays.sum() + (n - 1);
      checks++;
      if (!got_done || lat != exp_lat) begin errors++; $display("FAIL rand_latency_%0d: done %b lat %0d expected %0d", t, got_done, lat, exp_lat); end
      checks++;
      if ({bus.converged, bus.timeout, bus.iter_count} !== {conv, !conv, 8'(n)}) begin errors++; $display("FAIL rand_flags_%0d: conv/tmo/iter got %b/%b/%0d expected %b/%b/%0d", t, bus.converged, bus.timeout, bus.iter_count, conv, !conv, n); end
      checks++;
      if (steps != n - 1 || starts != n || overlap) begin errors++; $display("FAIL rand_pulses_%0d: steps %0d starts %0d overlap %b expected %0d %0d 0", t, steps, starts, overlap, n - 1, n); end
      checks++;
      if ({bus.q_measured, bus.dac_code} !== {vals[n-1], last_ref}) begin errors++; $display("FAIL rand_data_%0d: meas %0d dac %h expected %0d %h", t, bus.q_measured, bus.dac_code, vals[n-1], last_ref); end
    end
  endtask
  task automatic test_stray();
    adc_vals.delete();
    adc_vals.push_back(10'd605);
    run_solve(10'd600, 10'h2C3, 0, 1'b1);
    checks++;
    if (!got_done || lat != SC + 5 || starts != 1 || meas_moved) begin errors++; $display("FAIL stray_inputs: done %b lat %0d starts %0d moved %b expected 1 %0d 1 0", got_done, lat, starts, meas_moved, SC + 5); end
    checks++;
    if ({bus.converged, bus.iter_count, bus.q_measured} !== {1'b1, 8'd1, 10'd605}) begin errors++; $display("FAIL stray_result: conv/iter/meas got %b/%0d/%0d expected 1/1/605", bus.converged, bus.iter_count, bus.q_measured); end
  endtask
  task automatic test_abort();
    logic [BW-1:0] m0 = bus.q_measured;
    bit bad = 1'b0;
    bus.solver_i_ref = 10'h1A5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.converged, bus.timeout} !== 4'b0) begin errors++; $display("FAIL abort_state: busy/done/conv/tmo got %b expected 0000", {bus.busy, bus.done, bus.converged, bus.timeout}); end
    checks++;
    if ({bus.dac_code, bus.q_measured} !== {10'h1A5, m0}) begin errors++; $display("FAIL abort_hold: dac %h meas %0d expected 1a5 %0d", bus.dac_code, bus.q_measured, m0); end
    repeat (5) begin
      tick();
      if (bus.done || bus.busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_quiet: done/busy seen after abort, expected none"); end
  endtask
  task automatic test_watchdog();
    int c_start = -1;
    int c_done = -1;
    int n_start = 0;
    bit dn = 1'b0;
    bus.q_desired = 10'd258;
    bus.solver_i_ref = 10'h0F0;
    bus.adc_done = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 1100 && !dn; c++) begin
      tick();
      bus.start = 1'b0;
      n_start += int'(bus.adc_start);
      if (bus.adc_start && c_start < 0) c_start = c;
      if (bus.done) begin
        dn = 1'b1;
        c_done = c;
      end
    end
`ifdef SOLVER_SEQ_WATCHDOG_EN
    checks++;
    if (!dn || c_start != SC + 2 || c_done - c_start != AT) begin errors++; $display("FAIL watchdog_timing: adc_start at %0d done at %0d expected %0d and %0d", c_start, c_done, SC + 2, SC + 2 + AT); end
    tick();
    checks++;
    if ({bus.busy, bus.timeout, bus.converged, bus.iter_count} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin errors++; $display("FAIL watchdog_flags: busy/tmo/conv/iter got %b/%b/%b/%0d expected 0/1/0/1", bus.busy, bus.timeout, bus.converged, bus.iter_count); end
`else
    checks++;
    if (dn || bus.busy !== 1'b1 || c_start != SC + 2 || n_start != 1) begin errors++; $display("FAIL convert_wait: done %b busy %b adc_start at %0d count %0d expected 0 1 %0d 1", dn, bus.busy, c_start, n_start, SC + 2); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.converged} !== 3'b0) begin errors++; $display("FAIL convert_abort: busy/done/conv got %b expected 000", {bus.busy, bus.done, bus.converged}); end
`endif
  endtask
  task automatic test_rst_mid();
    bit seen = 1'b0;
    bus.solver_i_ref = 10'h2AA;
    bus.start = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      bus.start = 1'b0;
      seen = bus.adc_start;
    end
    tick();
    bus.adc_done = 1'b1;
    bus.adc_data = 10'd123;
    rst = 1'b1;
    tick();
    checks++;
    if (!seen || {bus.busy, bus.done, bus.adc_start, bus.solver_step, bus.converged, bus.timeout, bus.dac_code, bus.q_measured, bus.iter_count} !== '0)
      begin errors++; $display("FAIL rst_mid: seen %b outputs %h expected 0", seen, {bus.busy, bus.done, bus.adc_start, bus.solver_step, bus.converged, bus.timeout, bus.dac_code, bus.q_measured, bus.iter_count}); end
    rst = 1'b0;
    bus.adc_done = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.q_measured} !== '0) begin errors++; $display("FAIL rst_mid_idle: busy/meas got %b/%0d expected 0/0", bus.busy, bus.q_measured); end
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.q_desired = '0;
    bus.solver_i_ref = '0;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    test_reset();
    test_start_abort_idle();
    test_converge_first();
    test_max_iter();
    test_tol_boundary();
    test_random();
    test_stray();
    test_abort();
    test_watchdog();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/solver_sequencer.md
SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 10, the DAC/ADC code width.
REQ-002 SHALL have parameter TOL, default 30, the convergence tolerance in ADC LSBs.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, the analog settling wait after each DAC update (≥1).
REQ-004 SHALL have parameter MAX_ITER, default 32, the maximum solver iterations (1..255).
REQ-005 SHALL have parameter ADC_TIMEOUT, default 64, the watchdog limit in cycles (used only under the watchdog macro).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a solve (sampled in IDLE only)
- abort  in  1  cancel a solve in progress
- q_desired  in  BUS_WIDTH  target measurement
- solver_i_ref  in  BUS_WIDTH  current proposed by the solver
- solver_step  out  1  one-cycle pulse that advances the solver
- dac_code  out  BUS_WIDTH  registered code driven to the DAC
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  conversion complete
- adc_data  in  BUS_WIDTH  conversion result
- q_measured  out  BUS_WIDTH  latched ADC sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- converged  out  1  sticky: last solve met TOL
- timeout  out  1  sticky: last solve hit MAX_ITER or the watchdog
- iter_count  out  8  iterations completed in the current or last solve

Function
REQ-008 SHALL implement states IDLE, LOAD, SETTLE, CONVERT, CHECK, STEP and FINISH.
REQ-009 In IDLE with start=1, SHALL clear converged, timeout and iter_count, then go to LOAD next cycle.
REQ-010 In LOAD, SHALL register dac_code <= solver_i_ref and go to SETTLE (one cycle).
REQ-011 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to CONVERT.
REQ-012 adc_start SHALL be high only on the first CONVERT cycle.
- adc_done is honoured from the following cycle on.
- adc_done in any other state or cycle is ignored.
REQ-013 On adc_done in CONVERT, SHALL set q_measured <= adc_data and go to CHECK.
REQ-014 CHECK SHALL last one cycle and compute err = |adc_data_latched − q_desired| as signed BUS_WIDTH+1 bits, with no wrap.
REQ-015 CHECK SHALL exit as follows:
- err < TOL: set converged and go to FINISH.
- else if iter_count == MAX_ITER−1: set timeout and go to FINISH.
- else: go to STEP.
REQ-016 STEP SHALL assert solver_step for one cycle, increment iter_count (saturating at 255) and go to LOAD.
REQ-017 FINISH SHALL assert done for one cycle, increment iter_count, then go to IDLE.
REQ-018 Minimum latency from start to done with immediate adc_done SHALL be SETTLE_CYCLES+5 cycles.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE next cycle:
- no done pulse;
- dac_code and q_measured are held;
- converged stays 0 and timeout is unchanged.
REQ-020 If abort and adc_done occur in the same cycle, abort SHALL win.
REQ-021 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-022 solver_step, adc_start and done SHALL never be high in the same cycle.

Reset
REQ-023 rst SHALL force, next cycle:
- state = IDLE;
- dac_code, q_measured and iter_count = 0;
- solver_step, adc_start, done, busy, converged and timeout = 0.
REQ-024 rst mid-operation SHALL override abort, start and adc_done.

Configuration
REQ-025 Macro SOLVER_SEQ_WATCHDOG_EN defined: a counter SHALL run in CONVERT.
- If adc_done is absent for ADC_TIMEOUT cycles after adc_start, set timeout, assert done and go to IDLE via FINISH.
REQ-026 Macro SOLVER_SEQ_WATCHDOG_EN undefined: CONVERT SHALL wait indefinitely, and no watchdog logic is compiled.

Structure
REQ-027 The state enum typedef, the state width constant and the iteration counter width (8) SHALL reside in package solver_seq_pkg.
REQ-028 The absolute-error/tolerance comparison SHALL be a sub-module tol_compare (combinational; inputs a, b, tol; output within_tol).

Verification
REQ-029 q_desired=258, adc_data=270 on the first conversion -> converged=1, done after SETTLE_CYCLES+5 cycles, iter_count=1, solver_step never pulsed.
REQ-030 adc_data=500 always, q_desired=258, MAX_ITER=4 -> exactly 3 solver_step pulses, timeout=1, converged=0, iter_count=4.
REQ-031 abort asserted in the 3rd SETTLE cycle -> IDLE next cycle, no done, busy=0, dac_code holds solver_i_ref=0x1A5.
REQ-032 With the macro defined and adc_done never asserted, ADC_TIMEOUT=64 -> timeout=1 and done pulse 64 cycles after adc_start; without the macro -> still in CONVERT after 1000 cycles.
REQ-033 rst asserted mid-CONVERT with adc_done=1 that cycle -> all outputs 0 and IDLE next cycle, q_measured=0.
REQ-034 start pulsed while busy, and stray adc_done pulses in SETTLE -> no state change, q_measured unchanged.
